// File: rtl/lsu_mem_master_if.sv
// Request, response and pmem-style memory signals of the MEM-stage load/store initiator.
// The master modport is the initiator's view; slave is the pipeline/memory side.
interface lsu_mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;

    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_misalign;

    logic        mem_ce;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        output req_ready,
        output resp_valid, resp_rdata, resp_misalign,
        input  resp_ready,
        output mem_ce, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_rdata
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_misalign,
        output resp_ready,
        input  mem_ce, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_mem_master.sv
// MEM-stage load/store initiator: one request -> one aligned 8-byte memory access -> one response.
// Define LSU_PERF_EN to add the perf_loads / perf_stores / perf_misalign counters.
module lsu_mem_master #(
    parameter int MEM_LAT = 1,
    parameter int XLEN    = 64
) (
    input  logic                clk,
    input  logic                rst,
    lsu_mem_master_if.master    bus
`ifdef LSU_PERF_EN
    ,
    output logic [31:0]         perf_loads,
    output logic [31:0]         perf_stores,
    output logic [31:0]         perf_misalign
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, STORE, RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [2:0]        off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              mem_ce_q, mem_ce_d;
    logic              mem_we_q, mem_we_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [7:0]        mem_wmask_q, mem_wmask_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
    logic              resp_misalign_q, resp_misalign_d;
    logic              req_mis;
`ifdef LSU_PERF_EN
    logic [31:0]       perf_loads_q, perf_loads_d;
    logic [31:0]       perf_stores_q, perf_stores_d;
    logic [31:0]       perf_misalign_q, perf_misalign_d;
`endif

    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] raw,
                                                    input logic [2:0] off,
                                                    input logic [1:0] size,
                                                    input logic uns);
        logic [XLEN-1:0] sh;
        sh = raw >> {off, 3'b000};
        case (size)
            2'd0:    load_extend = uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            2'd1:    load_extend = uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            2'd2:    load_extend = uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: load_extend = sh;
        endcase
    endfunction

    function automatic logic [7:0] base_mask(input logic [1:0] size);
        case (size)
            2'd0:    base_mask = 8'h01;
            2'd1:    base_mask = 8'h03;
            2'd2:    base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
    endfunction

    always_comb begin
        case (bus.req_size)
            2'd1:    req_mis = bus.req_addr[0];
            2'd2:    req_mis = |bus.req_addr[1:0];
            2'd3:    req_mis = |bus.req_addr[2:0];
            default: req_mis = 1'b0;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        off_d           = off_q;
        size_d          = size_q;
        uns_d           = uns_q;
        mem_ce_d        = mem_ce_q;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        mem_wmask_d     = mem_wmask_q;
        resp_valid_d    = resp_valid_q;
        resp_rdata_d    = resp_rdata_q;
        resp_misalign_d = resp_misalign_q;
`ifdef LSU_PERF_EN
        perf_loads_d    = perf_loads_q;
        perf_stores_d   = perf_stores_q;
        perf_misalign_d = perf_misalign_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    off_d  = bus.req_addr[2:0];
                    size_d = bus.req_size;
                    uns_d  = bus.req_unsigned;
                    // A misaligned request skips memory entirely and leaves mem_* untouched.
                    if (req_mis) begin
                        state_d         = RESP;
                        resp_valid_d    = 1'b1;
                        resp_rdata_d    = '0;
                        resp_misalign_d = 1'b1;
`ifdef LSU_PERF_EN
                        perf_misalign_d = perf_misalign_q + 32'd1;
`endif
                    end else if (bus.req_we) begin
                        state_d     = STORE;
                        mem_ce_d    = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {bus.req_addr[XLEN-1:3], 3'b000};
                        mem_wmask_d = base_mask(bus.req_size) << bus.req_addr[2:0];
                        mem_wdata_d = bus.req_wdata << {bus.req_addr[2:0], 3'b000};
`ifdef LSU_PERF_EN
                        perf_stores_d = perf_stores_q + 32'd1;
`endif
                    end else begin
                        state_d     = LOAD;
                        mem_ce_d    = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_wmask_d = 8'h00;
                        mem_addr_d  = {bus.req_addr[XLEN-1:3], 3'b000};
                        cnt_d       = 4'(MEM_LAT - 1);
`ifdef LSU_PERF_EN
                        perf_loads_d = perf_loads_q + 32'd1;
`endif
                    end
                end
            end
            LOAD: begin
                if (cnt_q == 4'd0) begin
                    state_d         = RESP;
                    mem_ce_d        = 1'b0;
                    resp_valid_d    = 1'b1;
                    resp_rdata_d    = load_extend(bus.mem_rdata, off_q, size_q, uns_q);
                    resp_misalign_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STORE: begin
                state_d         = RESP;
                mem_ce_d        = 1'b0;
                mem_we_d        = 1'b0;
                resp_valid_d    = 1'b1;
                resp_rdata_d    = '0;
                resp_misalign_d = 1'b0;
            end
            default: begin
                if (bus.resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            off_q           <= '0;
            size_q          <= '0;
            uns_q           <= 1'b0;
            mem_ce_q        <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_wmask_q     <= '0;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= '0;
            resp_misalign_q <= 1'b0;
`ifdef LSU_PERF_EN
            perf_loads_q    <= '0;
            perf_stores_q   <= '0;
            perf_misalign_q <= '0;
`endif
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            off_q           <= off_d;
            size_q          <= size_d;
            uns_q           <= uns_d;
            mem_ce_q        <= mem_ce_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_wmask_q     <= mem_wmask_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_misalign_q <= resp_misalign_d;
`ifdef LSU_PERF_EN
            perf_loads_q    <= perf_loads_d;
            perf_stores_q   <= perf_stores_d;
            perf_misalign_q <= perf_misalign_d;
`endif
        end
    end

    assign bus.req_ready     = (state_q == IDLE);
    assign bus.mem_ce        = mem_ce_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.mem_wmask     = mem_wmask_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_rdata    = resp_rdata_q;
    assign bus.resp_misalign = resp_misalign_q;
`ifdef LSU_PERF_EN
    assign perf_loads        = perf_loads_q;
    assign perf_stores       = perf_stores_q;
    assign perf_misalign     = perf_misalign_q;
`endif

endmodule
